// File: rtl/decode_pkg.sv
// Shared decode types: fetch FSM states, prefix byte values and the
// instruction-field record handed from the fetch stage to the rest of decode.
package decode_pkg;

  typedef enum logic [1:0] {
    S_OPCODE = 2'd0,
    S_MODRM  = 2'd1,
    S_OUTPUT = 2'd2
  } fetch_state_t;

  localparam logic [7:0] PFX_ES       = 8'h26;
  localparam logic [7:0] PFX_CS       = 8'h2E;
  localparam logic [7:0] PFX_SS       = 8'h36;
  localparam logic [7:0] PFX_DS       = 8'h3E;
  localparam logic [7:0] PFX_FS       = 8'h64;
  localparam logic [7:0] PFX_GS       = 8'h65;
  localparam logic [7:0] PFX_OPSIZE   = 8'h66;
  localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
  localparam logic [7:0] PFX_LOCK     = 8'hF0;
  localparam logic [7:0] PFX_REPNE    = 8'hF2;
  localparam logic [7:0] PFX_REP      = 8'hF3;

  typedef struct packed {
    logic [7:0] opcode;
    logic       w;
    logic       w_in_instruction;
    logic [2:0] register_sequence_code;
    logic       has_modrm;
    logic [1:0] mod;
    logic [2:0] rm;
    logic       operand_size_32;
    logic [3:0] prefix_count;
    logic       unsupported;
    logic       prefix_overflow;
  } field_record_t;

  // Prefixes that only bump the count; the operand-size prefix is handled apart.
  function automatic logic is_plain_prefix(input logic [7:0] b);
    case (b)
      PFX_ES, PFX_CS, PFX_SS, PFX_DS, PFX_FS, PFX_GS,
      PFX_ADDRSIZE, PFX_LOCK, PFX_REPNE, PFX_REP: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_opcode_classify.sv
// Combinational opcode classifier: decides whether a ModRM byte follows and
// where the w bit and register sequence code come from.
module decode_opcode_classify (
  input  logic [7:0] opcode,
  output logic       has_modrm,
  output logic       w_in_instruction,
  output logic       w,
  output logic [2:0] embedded_code,
  output logic       uses_modrm_reg,
  output logic       unsupported
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    has_modrm        = 1'b0;
    w_in_instruction = 1'b0;
    w                = 1'b0;
    embedded_code    = 3'b000;
    uses_modrm_reg   = 1'b0;
    unsupported      = 1'b0;

    if (opcode[7:6] == 2'b00 && !opcode[2]) begin
      // ALU r/m forms 00-3F with low bits 0-3
      has_modrm        = 1'b1;
      w_in_instruction = 1'b1;
      w                = opcode[0];
      uses_modrm_reg   = 1'b1;
    end else if (opcode[7:6] == 2'b00 && opcode[2:1] == 2'b10) begin
      w_in_instruction = 1'b1;
      w                = opcode[0];
    end else if (opcode[7:5] == 3'b010 || opcode[7:3] == 5'b10010) begin
      w             = 1'b1;
      embedded_code = opcode[2:0];
    end else if (opcode >= 8'h84 && opcode <= 8'h8B) begin
      has_modrm        = 1'b1;
      w_in_instruction = 1'b1;
      w                = opcode[0];
      uses_modrm_reg   = 1'b1;
    end else if (opcode[7:4] == 4'hB) begin
      w_in_instruction = 1'b1;
      w                = opcode[3];
      embedded_code    = opcode[2:0];
    end else begin
      unsupported = 1'b1;
    end
  end

endmodule

// File: rtl/decode_opcode_modrm_fetch.sv
// Decode front stage: strips prefixes, captures opcode and optional ModRM,
// and holds one registered field record until downstream accepts it.
module decode_opcode_modrm_fetch
  import decode_pkg::*;
#(
  parameter bit          DEFAULT_OPERAND_SIZE_32 = 1'b1,
  parameter int unsigned MAX_PREFIX_COUNT        = 14
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_opcode,
  output logic       out_w,
  output logic       out_w_in_instruction,
  output logic [2:0] out_register_sequence_code,
  output logic       out_has_modrm,
  output logic [1:0] out_mod,
  output logic [2:0] out_rm,
  output logic       out_operand_size_32,
  output logic [3:0] out_prefix_count,
  output logic       out_unsupported,
  output logic       out_prefix_overflow
);

  localparam logic [4:0] MAX_COUNT = 5'(MAX_PREFIX_COUNT);

  fetch_state_t  state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic          override_q, override_d;
  logic [3:0]    count_q, count_d;
  field_record_t record_q, record_d;

  logic          accept;
  logic [4:0]    count_inc;
  logic [7:0]    cls_opcode;
  logic          cls_has_modrm;
  logic          cls_w_in_instruction;
  logic          cls_w;
  logic [2:0]    cls_embedded_code;
  logic          cls_uses_modrm_reg;
  logic          cls_unsupported;
  field_record_t record_load;

  assign byte_ready = (state_q != S_OUTPUT);
  assign out_valid  = (state_q == S_OUTPUT);
  assign accept     = byte_valid && byte_ready;
  assign count_inc  = {1'b0, count_q} + 5'd1;

  // In S_MODRM the latched opcode is reclassified so the record can be built
  // in the same cycle the ModRM byte arrives.
  assign cls_opcode = (state_q == S_OPCODE) ? byte_data : opcode_q;

  decode_opcode_classify u_classify (
    .opcode           (cls_opcode),
    .has_modrm        (cls_has_modrm),
    .w_in_instruction (cls_w_in_instruction),
    .w                (cls_w),
    .embedded_code    (cls_embedded_code),
    .uses_modrm_reg   (cls_uses_modrm_reg),
    .unsupported      (cls_unsupported)
  );

  always_comb begin
    record_load                        = '0;
    record_load.opcode                 = cls_opcode;
    record_load.w                      = cls_w;
    record_load.w_in_instruction       = cls_w_in_instruction;
    record_load.register_sequence_code = cls_uses_modrm_reg ? byte_data[5:3]
                                                            : cls_embedded_code;
    record_load.has_modrm              = cls_has_modrm;
    record_load.mod                    = cls_has_modrm ? byte_data[7:6] : 2'b00;
    record_load.rm                     = cls_has_modrm ? byte_data[2:0] : 3'b000;
    record_load.operand_size_32        = DEFAULT_OPERAND_SIZE_32 ^ override_q;
    record_load.prefix_count           = count_q;
    record_load.unsupported            = cls_unsupported;
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    override_d = override_q;
    count_d    = count_q;
    record_d   = record_q;

    case (state_q)
      S_OPCODE: begin
        if (accept) begin
          if (byte_data == PFX_OPSIZE || is_plain_prefix(byte_data)) begin
            count_d = count_inc[3:0];
            if (byte_data == PFX_OPSIZE) override_d = 1'b1;
            if (count_inc > MAX_COUNT) begin
              record_d                 = '0;
              record_d.prefix_overflow = 1'b1;
              record_d.prefix_count    = count_inc[3:0];
              record_d.operand_size_32 = DEFAULT_OPERAND_SIZE_32 ^ override_d;
              state_d                  = S_OUTPUT;
            end
          end else begin
            opcode_d = byte_data;
            if (cls_has_modrm) begin
              state_d = S_MODRM;
            end else begin
              record_d = record_load;
              state_d  = S_OUTPUT;
            end
          end
        end
      end
      S_MODRM: begin
        if (accept) begin
          record_d = record_load;
          state_d  = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          override_d               = 1'b0;
          count_d                  = '0;
          record_d.prefix_overflow = 1'b0;
          state_d                  = S_OPCODE;
        end
      end
      default: state_d = S_OPCODE;
    endcase

    // Flush wins over any same-cycle byte accept or output handshake.
    if (flush) begin
      state_d    = S_OPCODE;
      opcode_d   = '0;
      override_d = 1'b0;
      count_d    = '0;
      record_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_OPCODE;
      opcode_q   <= '0;
      override_q <= 1'b0;
      count_q    <= '0;
      record_q   <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      override_q <= override_d;
      count_q    <= count_d;
      record_q   <= record_d;
    end
  end

  assign out_opcode                 = record_q.opcode;
  assign out_w                      = record_q.w;
  assign out_w_in_instruction       = record_q.w_in_instruction;
  assign out_register_sequence_code = record_q.register_sequence_code;
  assign out_has_modrm              = record_q.has_modrm;
  assign out_mod                    = record_q.mod;
  assign out_rm                     = record_q.rm;
  assign out_operand_size_32        = record_q.operand_size_32;
  assign out_prefix_count           = record_q.prefix_count;
  assign out_unsupported            = record_q.unsupported;
  assign out_prefix_overflow        = record_q.prefix_overflow;

endmodule
